// File: rtl/czsctl.sv
`default_nettype none
// ============================================================================
// Module   : czsctl
// Purpose  : Call/return stack controller for the zevios core. Tracks the
//            stack pointer and occupancy and drives the czsmem stack-memory
//            port (address, write enable, write data). A popped return
//            address is presented one cycle after the request, using
//            czsmem's synchronous read-before-write behaviour.
// Options  : `define CZSCTL_WRAP_EN turns the stack into a circular buffer:
//            pushes when full overwrite the oldest entry instead of flagging
//            an overflow.
// Revision : 1.0 - initial release
// ============================================================================
module czsctl #(
  parameter int PC_WIDTH    = 10,
  parameter int STACK_WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   xRST_P,
  input  logic                   xPUSH_P,
  input  logic                   xPOP_P,
  input  logic [PC_WIDTH-1:0]    xPUSHD_P,
  input  logic                   xCLRERR_P,
  output logic [PC_WIDTH-1:0]    xPOPD_P,
  output logic                   xPOPV_P,
  output logic                   xFULL_P,
  output logic                   xEMPTY_P,
  output logic [STACK_WIDTH:0]   xDEPTH_P,
  output logic [1:0]             xERR_P,
  output logic [STACK_WIDTH-1:0] xSMEMA_P,
  output logic                   xSMEMWE_P,
  output logic [PC_WIDTH-1:0]    xSMEMDI_P,
  input  logic [PC_WIDTH-1:0]    xSMEMDO_P
);

  // Occupancy value meaning "every slot used".
  localparam logic [STACK_WIDTH:0] c_FULL_CNT = {1'b1, {STACK_WIDTH{1'b0}}};

  logic [STACK_WIDTH-1:0] sp_q, sp_d;
  logic [STACK_WIDTH:0]   cnt_q, cnt_d;
  logic                   popv_q, popv_d;
  logic [1:0]             err_q, err_d;

  logic [STACK_WIDTH-1:0] w_top;
  logic                   w_full;
  logic                   w_empty;
  logic [1:0]             w_err_set;
  logic [STACK_WIDTH-1:0] w_addr;
  logic                   w_we;

  assign w_top   = sp_q - 1'b1;
  assign w_full  = (cnt_q == c_FULL_CNT);
  assign w_empty = (cnt_q == '0);

  // Next-state decode: pointer/count updates, memory drive and error events.
  always_comb begin
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    popv_d    = 1'b0;
    w_err_set = 2'b00;
    w_addr    = w_top;
    w_we      = 1'b0;

    if (xPUSH_P && xPOP_P) begin
      if (!w_empty) begin
        // Replace the top entry; the old value is read out in the same
        // access thanks to the memory's read-before-write timing.
        w_addr = w_top;
        w_we   = 1'b1;
        popv_d = 1'b1;
      end else begin
        // Nothing to pop: flag underflow but still perform the push.
        w_err_set[1] = 1'b1;
        w_addr       = sp_q;
        w_we         = 1'b1;
        sp_d         = sp_q + 1'b1;
        cnt_d        = cnt_q + 1'b1;
      end
    end else if (xPUSH_P) begin
      w_addr = sp_q;
      if (!w_full) begin
        w_we  = 1'b1;
        sp_d  = sp_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
      end else begin
`ifdef CZSCTL_WRAP_EN
        // Circular mode: overwrite the oldest slot, occupancy stays full.
        w_we  = 1'b1;
        sp_d  = sp_q + 1'b1;
`else
        w_err_set[0] = 1'b1;
`endif
      end
    end else if (xPOP_P) begin
      if (!w_empty) begin
        w_addr = w_top;
        sp_d   = w_top;
        cnt_d  = cnt_q - 1'b1;
        popv_d = 1'b1;
      end else begin
        w_err_set[1] = 1'b1;
      end
    end

    // A new error event in the same cycle as a clear takes priority.
    err_d = (xCLRERR_P ? 2'b00 : err_q) | w_err_set;
  end

  // State registers with asynchronous reset; memory contents are untouched.
  always_ff @(posedge CLK or posedge xRST_P) begin
    if (xRST_P) begin
      sp_q   <= '0;
      cnt_q  <= '0;
      popv_q <= 1'b0;
      err_q  <= 2'b00;
    end else begin
      sp_q   <= sp_d;
      cnt_q  <= cnt_d;
      popv_q <= popv_d;
      err_q  <= err_d;
    end
  end

  assign xPOPD_P   = xSMEMDO_P;
  assign xPOPV_P   = popv_q;
  assign xFULL_P   = w_full;
  assign xEMPTY_P  = w_empty;
  assign xDEPTH_P  = cnt_q;
  assign xERR_P    = err_q;
  assign xSMEMA_P  = w_addr;
  assign xSMEMWE_P = w_we;
  assign xSMEMDI_P = xPUSHD_P;

endmodule
`default_nettype wire

// File: tb/tb_czsctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_czsctl
// Purpose  : Self-checking bench for czsctl with a czsmem-like memory model
//            and a queue-based LIFO reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_czsctl;

  localparam int PW = 10;
  localparam int SW = 4;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          xRST_P = 1'b1;
  logic          xPUSH_P = 1'b0;
  logic          xPOP_P = 1'b0;
  logic [PW-1:0] xPUSHD_P = '0;
  logic          xCLRERR_P = 1'b0;
  logic [PW-1:0] xPOPD_P;
  logic          xPOPV_P;
  logic          xFULL_P;
  logic          xEMPTY_P;
  logic [SW:0]   xDEPTH_P;
  logic [1:0]    xERR_P;
  logic [SW-1:0] xSMEMA_P;
  logic          xSMEMWE_P;
  logic [PW-1:0] xSMEMDI_P;
  logic [PW-1:0] xSMEMDO_P;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  czsctl #(.PC_WIDTH(PW), .STACK_WIDTH(SW)) dut (
    .CLK(CLK), .xRST_P(xRST_P), .xPUSH_P(xPUSH_P), .xPOP_P(xPOP_P),
    .xPUSHD_P(xPUSHD_P), .xCLRERR_P(xCLRERR_P), .xPOPD_P(xPOPD_P),
    .xPOPV_P(xPOPV_P), .xFULL_P(xFULL_P), .xEMPTY_P(xEMPTY_P),
    .xDEPTH_P(xDEPTH_P), .xERR_P(xERR_P), .xSMEMA_P(xSMEMA_P),
    .xSMEMWE_P(xSMEMWE_P), .xSMEMDI_P(xSMEMDI_P), .xSMEMDO_P(xSMEMDO_P)
  );

  // czsmem stand-in: synchronous read, old data returned on a write.
  logic [PW-1:0] mem [DEPTH];
  logic [PW-1:0] mem_do = '0;
  initial foreach (mem[i]) mem[i] = '0;
  always @(posedge CLK) begin
    mem_do <= mem[xSMEMA_P];
    if (xSMEMWE_P) mem[xSMEMA_P] <= xSMEMDI_P;
  end
  assign xSMEMDO_P = mem_do;

  // Reference model: a plain LIFO of values plus expected flags.
  int            q[$];
  logic [1:0]    exp_err  = 2'b00;
  logic          exp_popv = 1'b0;
  logic [PW-1:0] exp_popd = '0;

  task automatic step(input logic pu, input logic po, input logic [PW-1:0] d,
                      input logic cl);
    logic [1:0] set;
    xPUSH_P = pu; xPOP_P = po; xPUSHD_P = d; xCLRERR_P = cl;
    @(posedge CLK);
    set = 2'b00;
    exp_popv = 1'b0;
    if (po) begin
      if (q.size() == 0) set[1] = 1'b1;
      else begin
        exp_popd = PW'(q.pop_back());
        exp_popv = 1'b1;
      end
    end
    if (pu) begin
      if (q.size() < DEPTH) q.push_back(int'(d));
      else begin
`ifdef CZSCTL_WRAP_EN
        void'(q.pop_front());
        q.push_back(int'(d));
`else
        set[0] = 1'b1;
`endif
      end
    end
    exp_err = (cl ? 2'b00 : exp_err) | set;
    @(negedge CLK);
    xPUSH_P = 1'b0; xPOP_P = 1'b0; xCLRERR_P = 1'b0;
  endtask

  task automatic drain_and_clear();
    while (q.size() > 0) step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({xPOPV_P, xEMPTY_P, xFULL_P, xDEPTH_P, xERR_P} !== {1'b0, 1'b1, 1'b0, 5'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: popv=%b empty=%b full=%b depth=%0d err=%b required 0 1 0 0 00",
               xPOPV_P, xEMPTY_P, xFULL_P, xDEPTH_P, xERR_P);
    end
  endtask

  task automatic test_lifo();
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, PW'(i), 1'b0);
    for (int i = 3; i >= 1; i--) begin
      step(1'b0, 1'b1, '0, 1'b0);
      n_checks++;
      if (xPOPV_P !== 1'b1 || xPOPD_P !== PW'(i)) begin
        n_fail++;
        $display("FAIL lifo_pop: popv=%b popd=%h required 1 %h", xPOPV_P, xPOPD_P, PW'(i));
      end
    end
    step(1'b0, 1'b0, '0, 1'b0);
    n_checks++;
    if (xEMPTY_P !== 1'b1 || xDEPTH_P !== 5'd0 || xPOPV_P !== 1'b0) begin
      n_fail++;
      $display("FAIL lifo_end: empty=%b depth=%0d popv=%b required 1 0 0", xEMPTY_P, xDEPTH_P, xPOPV_P);
    end
  endtask

  task automatic test_overflow();
    logic          exp_we;
    logic [1:0]    err_ovf, err_final;
    logic [PW-1:0] first_pop;
`ifdef CZSCTL_WRAP_EN
    exp_we = 1'b1; err_ovf = 2'b00; err_final = 2'b10; first_pop = 10'h3FF;
`else
    exp_we = 1'b0; err_ovf = 2'b01; err_final = 2'b11; first_pop = 10'h10F;
`endif
    drain_and_clear();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, PW'(10'h100 + i), 1'b0);
    n_checks++;
    if (xFULL_P !== 1'b1 || xDEPTH_P !== 5'd16 || xERR_P !== 2'b00) begin
      n_fail++;
      $display("FAIL full_flag: full=%b depth=%0d err=%b required 1 16 00", xFULL_P, xDEPTH_P, xERR_P);
    end
    xPUSH_P = 1'b1; xPUSHD_P = 10'h3FF;
    #1;
    n_checks++;
    if (xSMEMWE_P !== exp_we) begin
      n_fail++;
      $display("FAIL full_push_we: we=%b required %b", xSMEMWE_P, exp_we);
    end
    step(1'b1, 1'b0, 10'h3FF, 1'b0);
    n_checks++;
    if (xERR_P !== err_ovf || xFULL_P !== 1'b1 || xDEPTH_P !== 5'd16) begin
      n_fail++;
      $display("FAIL overflow: err=%b full=%b depth=%0d required %b 1 16", xERR_P, xFULL_P, xDEPTH_P, err_ovf);
    end
    step(1'b0, 1'b1, '0, 1'b0);
    n_checks++;
    if (xPOPV_P !== 1'b1 || xPOPD_P !== first_pop) begin
      n_fail++;
      $display("FAIL overflow_pop: popv=%b popd=%h required 1 %h", xPOPV_P, xPOPD_P, first_pop);
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      n_checks++;
      if (xPOPV_P !== 1'b1 || xPOPD_P !== exp_popd) begin
        n_fail++;
        $display("FAIL overflow_drain: popv=%b popd=%h required 1 %h", xPOPV_P, xPOPD_P, exp_popd);
      end
    end
    step(1'b0, 1'b1, '0, 1'b0);
    n_checks++;
    if (xPOPV_P !== 1'b0 || xERR_P !== err_final || xEMPTY_P !== 1'b1) begin
      n_fail++;
      $display("FAIL extra_pop: popv=%b err=%b empty=%b required 0 %b 1", xPOPV_P, xERR_P, xEMPTY_P, err_final);
    end
  endtask

  task automatic test_underflow_clear();
    drain_and_clear();
    step(1'b0, 1'b1, '0, 1'b0);
    n_checks++;
    if (xPOPV_P !== 1'b0 || xERR_P !== 2'b10 || xDEPTH_P !== 5'd0) begin
      n_fail++;
      $display("FAIL underflow: popv=%b err=%b depth=%0d required 0 10 0", xPOPV_P, xERR_P, xDEPTH_P);
    end
    step(1'b0, 1'b0, '0, 1'b0);
    n_checks++;
    if (xERR_P !== 2'b10) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b required 10", xERR_P);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (xERR_P !== 2'b00) begin
      n_fail++;
      $display("FAIL err_clear: err=%b required 00", xERR_P);
    end
    // Clear and a new underflow together: the new event survives.
    step(1'b0, 1'b1, '0, 1'b1);
    n_checks++;
    if (xERR_P !== 2'b10) begin
      n_fail++;
      $display("FAIL set_beats_clear: err=%b required 10", xERR_P);
    end
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_replace();
    drain_and_clear();
    step(1'b1, 1'b0, 10'h0AA, 1'b0);
    step(1'b1, 1'b1, 10'h055, 1'b0);
    n_checks++;
    if (xPOPV_P !== 1'b1 || xPOPD_P !== 10'h0AA || xDEPTH_P !== 5'd1) begin
      n_fail++;
      $display("FAIL replace: popv=%b popd=%h depth=%0d required 1 0aa 1", xPOPV_P, xPOPD_P, xDEPTH_P);
    end
    step(1'b0, 1'b1, '0, 1'b0);
    n_checks++;
    if (xPOPV_P !== 1'b1 || xPOPD_P !== 10'h055 || xEMPTY_P !== 1'b1) begin
      n_fail++;
      $display("FAIL replace_pop: popv=%b popd=%h empty=%b required 1 055 1", xPOPV_P, xPOPD_P, xEMPTY_P);
    end
  endtask

  task automatic test_pushpop_empty();
    drain_and_clear();
    step(1'b1, 1'b1, 10'h077, 1'b0);
    n_checks++;
    if (xPOPV_P !== 1'b0 || xERR_P !== 2'b10 || xDEPTH_P !== 5'd1) begin
      n_fail++;
      $display("FAIL pushpop_empty: popv=%b err=%b depth=%0d required 0 10 1", xPOPV_P, xERR_P, xDEPTH_P);
    end
    step(1'b0, 1'b1, '0, 1'b0);
    n_checks++;
    if (xPOPV_P !== 1'b1 || xPOPD_P !== 10'h077) begin
      n_fail++;
      $display("FAIL pushpop_empty_pop: popv=%b popd=%h required 1 077", xPOPV_P, xPOPD_P);
    end
  endtask

  task automatic test_random();
    logic pu, po, cl;
    drain_and_clear();
    for (int n = 0; n < 400; n++) begin
      // Bias toward pushes early and pops late so both full and empty occur.
      pu = ($urandom_range(0, 99) < ((n % 100) < 50 ? 70 : 30));
      po = ($urandom_range(0, 99) < ((n % 100) < 50 ? 30 : 70));
      cl = ($urandom_range(0, 19) == 0);
      step(pu, po, PW'($urandom_range(0, 1023)), cl);
      n_checks++;
      if (xPOPV_P !== exp_popv || (exp_popv && xPOPD_P !== exp_popd) ||
          xDEPTH_P !== (SW+1)'(q.size()) || xERR_P !== exp_err ||
          xFULL_P !== (q.size() == DEPTH) || xEMPTY_P !== (q.size() == 0)) begin
        n_fail++;
        $display("FAIL random[%0d]: popv=%b popd=%h depth=%0d err=%b full=%b empty=%b required %b %h %0d %b %b %b",
                 n, xPOPV_P, xPOPD_P, xDEPTH_P, xERR_P, xFULL_P, xEMPTY_P,
                 exp_popv, exp_popd, q.size(), exp_err, q.size() == DEPTH, q.size() == 0);
      end
    end
  endtask

  task automatic test_async_reset();
    drain_and_clear();
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b1, 1'b0, 10'h123, 1'b0);
    step(1'b1, 1'b0, 10'h124, 1'b0);
    xPOP_P = 1'b1;
    @(posedge CLK);
    #1;
    xPOP_P = 1'b0;
    n_checks++;
    if (xPOPV_P !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_popv: popv=%b required 1", xPOPV_P);
    end
    #1 xRST_P = 1'b1;
    #1;
    n_checks++;
    if ({xPOPV_P, xEMPTY_P, xDEPTH_P, xERR_P} !== {1'b0, 1'b1, 5'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL async_reset: popv=%b empty=%b depth=%0d err=%b required 0 1 0 00",
               xPOPV_P, xEMPTY_P, xDEPTH_P, xERR_P);
    end
    q.delete();
    exp_err = 2'b00;
    exp_popv = 1'b0;
    @(negedge CLK);
    xRST_P = 1'b0;
    step(1'b1, 1'b0, 10'h2A5, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    n_checks++;
    if (xPOPV_P !== 1'b1 || xPOPD_P !== 10'h2A5 || xEMPTY_P !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_pop: popv=%b popd=%h empty=%b required 1 2a5 1", xPOPV_P, xPOPD_P, xEMPTY_P);
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    xRST_P = 1'b0;
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow_clear();
    test_replace();
    test_pushpop_empty();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
